// File: rtl/rr_selector_if.sv
// Request/grant bundle for rr_selector: request and slot readiness in,
// per-slot grant indices, valid bits, grant mask and grant count out.
interface rr_selector_if #(
    parameter int Q_SIZE = 32,
    parameter int S_SIZE = 3
);
    localparam int INDEX_LEN = (Q_SIZE > 1) ? $clog2(Q_SIZE) : 1;
    localparam int CNT_LEN   = $clog2(S_SIZE + 1);

    logic [Q_SIZE-1:0]                 request;
    logic [S_SIZE-1:0]                 slot_ready;
    logic [S_SIZE-1:0][INDEX_LEN-1:0]  select;
    logic [S_SIZE-1:0]                 valid;
    logic [Q_SIZE-1:0]                 grant_mask;
    logic [CNT_LEN-1:0]                grant_count;

    modport master (
        output request, slot_ready,
        input  select, valid, grant_mask, grant_count
    );

    modport slave (
        input  request, slot_ready,
        output select, valid, grant_mask, grant_count
    );
endinterface

// File: rtl/rr_selector.sv
// Multi-slot round-robin selector: grants up to S_SIZE requesting entries per
// cycle, scanning from a rotating priority pointer.
module rr_selector #(
    parameter int Q_SIZE = 32,
    parameter int S_SIZE = 3
) (
    input  logic          clock,
    input  logic          reset,
    rr_selector_if.slave  bus
);
    localparam int INDEX_LEN = (Q_SIZE > 1) ? $clog2(Q_SIZE) : 1;
    localparam int CNT_LEN   = $clog2(S_SIZE + 1);
    localparam logic [INDEX_LEN:0]   Q_WIDE = (INDEX_LEN + 1)'(Q_SIZE);
    localparam logic [INDEX_LEN-1:0] Q_LAST = INDEX_LEN'(Q_SIZE - 1);

    logic [INDEX_LEN-1:0]              ptr;
    logic [INDEX_LEN-1:0]              ptr_next;
    logic [INDEX_LEN-1:0]              last;
    logic [INDEX_LEN-1:0]              idx;
    logic [INDEX_LEN:0]                pos;
    logic [CNT_LEN-1:0]                rank [S_SIZE];
    logic [CNT_LEN-1:0]                n_ready;
    logic [CNT_LEN-1:0]                n_grant;
    logic                              taken;
    logic [S_SIZE-1:0][INDEX_LEN-1:0]  sel;
    logic [S_SIZE-1:0]                 vld;
    logic [Q_SIZE-1:0]                 mask;

    always_comb begin
        // rank[k] = number of ready slots below k; the n-th grant goes to the
        // ready slot whose rank is n.
        n_ready = '0;
        for (int unsigned k = 0; k < S_SIZE; k++) begin
            rank[k] = n_ready;
            if (bus.slot_ready[k]) n_ready = n_ready + CNT_LEN'(1);
        end

        sel     = '0;
        vld     = '0;
        mask    = '0;
        n_grant = '0;
        last    = ptr;
        pos     = '0;
        idx     = '0;
        taken   = 1'b0;
        for (int unsigned j = 0; j < Q_SIZE; j++) begin
            pos = {1'b0, ptr} + (INDEX_LEN + 1)'(j);
            if (pos >= Q_WIDE) pos = pos - Q_WIDE;
            idx   = pos[INDEX_LEN-1:0];
            taken = 1'b0;
            if (bus.request[idx]) begin
                for (int unsigned k = 0; k < S_SIZE; k++) begin
                    if (!taken && bus.slot_ready[k] && (rank[k] == n_grant)) begin
                        sel[k]    = idx;
                        vld[k]    = 1'b1;
                        mask[idx] = 1'b1;
                        last      = idx;
                        taken     = 1'b1;
                    end
                end
            end
            if (taken) n_grant = n_grant + CNT_LEN'(1);
        end

        ptr_next = (last == Q_LAST) ? '0 : last + INDEX_LEN'(1);
    end

    always_comb begin
        bus.select      = reset ? '0 : sel;
        bus.valid       = reset ? '0 : vld;
        bus.grant_mask  = reset ? '0 : mask;
        bus.grant_count = reset ? '0 : n_grant;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (n_grant != '0) begin
            ptr <= ptr_next;
        end
    end
endmodule

// File: doc/rr_selector.md
RR_SELECTOR -- requirements
Module: rr_selector

Interface
REQ-001 SHALL have parameter Q_SIZE, default 32: number of request lines (issue-queue entries), legal range 2..64.
REQ-002 SHALL have parameter S_SIZE, default 3: number of grant slots per cycle, legal range 1..Q_SIZE.
REQ-003 SHALL have localparam INDEX_LEN = ceil(log2(Q_SIZE)), minimum 1: width of one index.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port request, input, Q_SIZE: bit i set = entry i requests a grant.
REQ-007 SHALL have port slot_ready, input, S_SIZE: bit k set = slot k can accept a grant this cycle.
REQ-008 SHALL have port select, output, S_SIZE x INDEX_LEN: index granted to slot k.
REQ-009 SHALL have port valid, output, S_SIZE: bit k set = select[k] holds a real grant.
REQ-010 SHALL have port grant_mask, output, Q_SIZE: one-hot-per-grant mask of all granted indices.
REQ-011 SHALL have port grant_count, output, ceil(log2(S_SIZE+1)): number of valid grants this cycle.

Function
REQ-012 SHALL hold one state register ptr (INDEX_LEN bits, range 0..Q_SIZE-1): the highest-priority index.
REQ-013 SHALL compute grants combinationally from request, slot_ready and ptr, with zero-cycle latency.
REQ-014 SHALL scan indices in the order ptr, ptr+1, ..., Q_SIZE-1, 0, ..., ptr-1 (modulo Q_SIZE).
REQ-015 SHALL assign the n-th requesting index found in scan order to the n-th ready slot, in ascending slot number.
REQ-016 SHALL set valid[k]=0 and select[k]=0 for every slot with slot_ready[k]=0.
REQ-017 SHALL set valid[k]=0 and select[k]=0 for every ready slot left over when requests run out.
REQ-018 SHALL never grant the same index to two slots in one cycle.
REQ-019 SHALL set grant_mask[i]=1 exactly for indices granted this cycle; popcount(grant_mask) SHALL equal grant_count, which SHALL equal popcount(valid).
REQ-020 SHALL update ptr at the clock edge when grant_count>0, to (last index granted in scan order + 1) mod Q_SIZE.
REQ-021 SHALL hold ptr unchanged when grant_count=0, whether because request=0 or slot_ready=0.
REQ-022 SHALL, under continuous request of index i, grant i within ceil(Q_SIZE/1) cycles in which at least one slot is ready (starvation freedom).
REQ-023 SHALL treat wrap-around seamlessly: a scan from ptr=Q_SIZE-1 continues at 0, and an update of Q_SIZE-1+1 SHALL yield 0.
REQ-024 SHALL handle Q_SIZE values that are not powers of two: ptr SHALL never take a value >= Q_SIZE.

Reset
REQ-025 SHALL set ptr to 0 at a clock edge where reset=1, overriding any grant-driven update in that cycle.
REQ-026 SHALL, while reset=1, force valid=0, select=0, grant_mask=0 and grant_count=0 regardless of request and slot_ready.
REQ-027 SHALL, in the first cycle after reset deasserts, compute grants with ptr=0; no other state exists.

Verification
All scenarios use Q_SIZE=8 and S_SIZE=3.
REQ-028 SHALL cover the rotation scenario:
- After reset, request=8'hFF and slot_ready=3'b111 held.
- Cycle 1: select={0,1,2}, valid=111.
- Cycle 2: select={3,4,5}.
- Cycle 3: select={6,7,0}.
- ptr then = 1.
REQ-029 SHALL cover the wrap scenario: ptr=6, request=8'b0100_0101 -> slot0=6, slot1=0, slot2=2, grant_mask=8'h45, grant_count=3, next ptr=3.
REQ-030 SHALL cover the backpressure scenario: ptr=0, request=8'hFF, slot_ready=3'b101 -> slot0=0, valid[1]=0, slot2=1, grant_count=2, next ptr=2.
REQ-031 SHALL cover the sparse scenario:
- ptr=0, request=8'h20 -> valid=001, select[0]=5, next ptr=6.
- Then request=0 -> valid=000, ptr stays 6.
REQ-032 SHALL cover the mid-operation reset scenario: ptr=5, request=8'hFF, reset=1 for one cycle -> outputs all 0 during reset; next cycle ptr=0 and select={0,1,2}.
REQ-033 SHALL run a random-stimulus checker against a reference model, checking REQ-018, REQ-019 and REQ-022 every cycle.
